rob_ptr_ctrl: RTL
=================

# rob_ptr_ctrl

Parametrised reorder-buffer pointer controller for the out-of-order core. It allocates up to `allocWidth` ROB entries per cycle at the tail and retires up to `commitWidth` entries per cycle at the head. It rolls the tail back to a checkpoint on a branch flush. Pointers carry an extra wrap bit, so full and empty are exact, and every ROB slot is usable.

## Interface
Parameters:
- `ROBsize`, 16: number of entries; power of 2, ≥ 4.
- `allocWidth`, 2: maximum allocations per cycle; 1..ROBsize/2.
- `commitWidth`, 2: maximum commits per cycle; 1..ROBsize/2.
- `addrSize`, $clog2(ROBsize): index width. Derived; not overridden.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `reset_i` in 1: reset, synchronous, active-high.
- `allocCount_i` in $clog2(allocWidth+1): number of entries requested this cycle.
- `commitCount_i` in $clog2(commitWidth+1): number of head entries retiring this cycle.
- `flush_i` in 1: roll the tail back to `flushTail_i`.
- `flushTail_i` in addrSize+1: checkpointed tail pointer, including the wrap bit.
- `allocGrant_o` out 1: the whole request is accepted this cycle. Combinational.
- `stall_o` out 1: `allocCount_i != 0` and `!allocGrant_o`. Combinational.
- `head_o` out addrSize: index of the oldest entry.
- `tail_o` out addrSize: index of the first slot to allocate; slot k of a group is `(tail_o + k) mod ROBsize`.
- `tailPtr_o` out addrSize+1: tail pointer with wrap bit; front end checkpoints this per branch.
- `count_o` out addrSize+1: number of occupied entries, 0..ROBsize.
- `freeSlots_o` out addrSize+1: `ROBsize - count_o`.
- `full_o` out 1: `count_o == ROBsize`.
- `empty_o` out 1: `count_o == 0`.
- `error_o` out 1: sticky protocol-violation flag.

## Operation
- State:
  - `headPtr` and `tailPtr`, each addrSize+1 bits; all arithmetic is modulo 2·ROBsize.
  - `error`, 1 bit.
- Index and count derivation:
  - Index = pointer[addrSize-1:0].
  - count = tailPtr − headPtr, modulo 2·ROBsize.
- Effective commit:
  - effCommit = min(`commitCount_i`, count).
  - If `commitCount_i` > count, `error` is set.
  - headPtr ← headPtr + effCommit.
- Allocation grant:
  - `allocGrant_o` = !`flush_i` && `allocCount_i` ≤ `freeSlots_o`.
  - The grant uses the registered count. Slots freed by a same-cycle commit are not reusable until the next cycle.
  - A request of 0 gives grant = 1 and no stall.
  - The grant is all-or-nothing; there is no partial allocation.
- Tail update on a grant: tailPtr ← tailPtr + `allocCount_i`.
- Flush (highest priority on the tail):
  - Allocation is suppressed that cycle.
  - Legal when `flushTail_i` lies in [headPtr + effCommit, tailPtr], with the distance measured modulo 2·ROBsize. In that case tailPtr ← `flushTail_i`.
  - Illegal flush: tailPtr ← headPtr + effCommit (ROB emptied) and `error` is set.
  - Commits apply normally in a flush cycle.
- `error` clears only on reset.
- Every output except `allocGrant_o` and `stall_o` is derived from registers only (Moore).

## Timing
- Reset (synchronous, overrides everything):
  - headPtr = tailPtr = 0 and error = 0.
  - Outputs next cycle: head/tail 0, `tailPtr_o` 0, `count_o` 0, `freeSlots_o` ROBsize, `empty_o` 1, `full_o` 0, `error_o` 0.
  - While reset is high, `allocGrant_o` is 0.
  - Asserting reset mid-stream discards all in-flight allocations the same edge.
- Latency:
  - A granted allocation is visible in `tail_o`, `count_o` and `full_o` one cycle after the request edge.
  - A commit is visible in `head_o` and `count_o` one cycle later.
- Wrap-around:
  - Indices wrap from ROBsize−1 to 0 and the wrap bit toggles.
  - head index == tail index means empty if the wrap bits match, full otherwise.
- Simultaneous events (same edge):
  - Alloc + commit: both pointers move together.
  - Flush + commit: the head moves and the tail is restored.
  - Flush + alloc: the allocation is dropped and `stall_o` is 1.
- Full with a commit request: there is no bypass; the stall persists for that cycle.

## Test plan
All scenarios use ROBsize=8, allocWidth=2, commitWidth=2.
1. Reset, then `allocCount_i`=2 for 4 cycles → `tail_o` goes 0,2,4,6,0; `tailPtr_o` ends at 8; `count_o`=8; `full_o`=1. A fifth request gives grant 0 and `stall_o`=1.
2. From full, commit 2 and alloc 2 in the same cycle → grant 0. Next cycle `head_o`=2, `count_o`=6. Repeating alloc 2 is then granted and `count_o` returns to 8.
3. With `count_o`=1, `commitCount_i`=2 → `head_o` advances by 1, `empty_o`=1, `error_o`=1. `error_o` stays set until `reset_i`.
4. headPtr=0, tailPtr=6, `flush_i`=1 with `flushTail_i`=3, plus `allocCount_i`=2 → grant 0. Next cycle `tail_o`=3, `count_o`=3.
5. headPtr=2, tailPtr=6, flush to 7 (beyond the tail) → tail set to 2, `count_o`=0, `error_o`=1.
6. Fill and drain repeatedly across 3 full wraps, with random legal alloc/commit counts → `count_o` always matches a scoreboard. `full_o` and `empty_o` are never both 1. `reset_i` mid-stream gives all-zero state next cycle.

Source files
------------

// File: rtl/rob_ptr_ctrl_if.sv
// Front-end / commit-side signal bundle for the ROB pointer controller.
// master: allocation/commit/flush requester. slave: rob_ptr_ctrl.
interface rob_ptr_ctrl_if #(
  parameter int ROBsize     = 16,
  parameter int allocWidth  = 2,
  parameter int commitWidth = 2
);
  localparam int addrSize = $clog2(ROBsize);
  localparam int ACW      = $clog2(allocWidth + 1);
  localparam int CCW      = $clog2(commitWidth + 1);

  logic [ACW-1:0]      allocCount_i;
  logic [CCW-1:0]      commitCount_i;
  logic                flush_i;
  logic [addrSize:0]   flushTail_i;
  logic                allocGrant_o;
  logic                stall_o;
  logic [addrSize-1:0] head_o;
  logic [addrSize-1:0] tail_o;
  logic [addrSize:0]   tailPtr_o;
  logic [addrSize:0]   count_o;
  logic [addrSize:0]   freeSlots_o;
  logic                full_o;
  logic                empty_o;
  logic                error_o;

  modport master (
    output allocCount_i, commitCount_i, flush_i, flushTail_i,
    input  allocGrant_o, stall_o, head_o, tail_o, tailPtr_o,
           count_o, freeSlots_o, full_o, empty_o, error_o
  );

  modport slave (
    input  allocCount_i, commitCount_i, flush_i, flushTail_i,
    output allocGrant_o, stall_o, head_o, tail_o, tailPtr_o,
           count_o, freeSlots_o, full_o, empty_o, error_o
  );
endinterface

// File: rtl/rob_ptr_ctrl.sv
// Reorder-buffer head/tail pointer controller. Pointers carry one extra
// wrap bit so occupancy is exact from 0 to ROBsize; tail can be rolled
// back to a front-end checkpoint on a branch flush.
module rob_ptr_ctrl #(
  parameter int ROBsize     = 16,
  parameter int allocWidth  = 2,
  parameter int commitWidth = 2
) (
  input logic           clk_i,
  input logic           reset_i,
  rob_ptr_ctrl_if.slave rob
);
  localparam int addrSize = $clog2(ROBsize);
  localparam int PW       = addrSize + 1;

  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic          err_q;

  logic [PW-1:0] count;
  logic [PW-1:0] free_slots;
  logic [PW-1:0] commit_req;
  logic [PW-1:0] alloc_req;
  logic [PW-1:0] eff_commit;
  logic [PW-1:0] new_head;
  logic [PW-1:0] flush_dist;
  logic [PW-1:0] live_dist;
  logic [PW-1:0] tail_nxt;
  logic          over_commit;
  logic          flush_ok;
  logic          grant;
  logic          err_nxt;

  // Occupancy, commit clamping, flush legality and next-pointer selection.
  always_comb begin
    count       = tail_ptr - head_ptr;
    free_slots  = PW'(ROBsize) - count;
    commit_req  = PW'(rob.commitCount_i);
    alloc_req   = PW'(rob.allocCount_i);
    over_commit = commit_req > count;
    eff_commit  = over_commit ? count : commit_req;
    new_head    = head_ptr + eff_commit;
    // Checkpoint is legal when it sits between the post-commit head and the
    // current tail; both distances are taken modulo 2*ROBsize from new_head.
    flush_dist  = rob.flushTail_i - new_head;
    live_dist   = tail_ptr - new_head;
    flush_ok    = flush_dist <= live_dist;
    // Grant looks at the registered count only: same-cycle commits do not
    // free space for this cycle's allocation.
    grant       = !reset_i && !rob.flush_i && (alloc_req <= free_slots);

    tail_nxt = tail_ptr;
    err_nxt  = err_q | over_commit;
    if (rob.flush_i) begin
      if (flush_ok) begin
        tail_nxt = rob.flushTail_i;
      end else begin
        tail_nxt = new_head;
        err_nxt  = 1'b1;
      end
    end else if (grant) begin
      tail_nxt = tail_ptr + alloc_req;
    end
  end

  // Pointer and sticky error registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      err_q    <= 1'b0;
    end else begin
      head_ptr <= new_head;
      tail_ptr <= tail_nxt;
      err_q    <= err_nxt;
    end
  end

  assign rob.allocGrant_o = grant;
  assign rob.stall_o      = (rob.allocCount_i != '0) && !grant;
  assign rob.head_o       = head_ptr[addrSize-1:0];
  assign rob.tail_o       = tail_ptr[addrSize-1:0];
  assign rob.tailPtr_o    = tail_ptr;
  assign rob.count_o      = count;
  assign rob.freeSlots_o  = free_slots;
  assign rob.full_o       = count == PW'(ROBsize);
  assign rob.empty_o      = count == '0;
  assign rob.error_o      = err_q;
endmodule
